// File: rtl/mp_add_pkg.sv
// Shared types and defaults for the multi-precision add/sub sequencer.
// Holds the FSM state encoding and the default chunk width/count.
package mp_add_pkg;

  localparam int DEF_N = 8;
  localparam int DEF_K = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/n_bit_adder.sv
// Plain N-bit ripple adder with carry in and carry out.
// Ports: i_a, i_b (N), i_ci (1) -> o_s (N), o_co (1).
module n_bit_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_ci,
  output logic [N-1:0] o_s,
  output logic         o_co
);

  logic [N:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_ci};
  assign o_s   = w_sum[N-1:0];
  assign o_co  = w_sum[N];

endmodule

// File: rtl/mp_add_sequencer.sv
// W = N*K bit add/sub done one N-bit chunk per cycle through one adder.
// Ports: clk, rst (sync, high), start, sub, a, b -> busy, done, s, co, ovf.
module mp_add_sequencer
  import mp_add_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int K = DEF_K
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           sub,
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [N*K-1:0] s,
  output logic           co,
  output logic           ovf
);

  localparam int W  = N * K;
  localparam int IW = $clog2(K);

  state_t         r_state;
  state_t         w_next;
  logic [IW-1:0]  r_idx;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_carry;
  logic [W-1:0]   r_s;
  logic           r_co;
  logic           r_ovf;

  logic [N-1:0]   w_opa;
  logic [N-1:0]   w_opb;
  logic [N-1:0]   w_sum;
  logic           w_cout;
  logic           w_last;
  logic           w_accept;
  logic           w_cmsb;

  assign w_opa    = r_a[N*r_idx +: N];
  assign w_opb    = r_b[N*r_idx +: N];
  assign w_last   = (r_idx == IW'(K - 1));
  assign w_accept = start &&
                    (r_state == ST_IDLE || r_state == ST_DONE);
  // Carry into the MSB recovered from the MSB sum bit.
  assign w_cmsb   = w_sum[N-1] ^ w_opa[N-1] ^ w_opb[N-1];

  n_bit_adder #(
    .N (N)
  ) u_add (
    .i_a  (w_opa),
    .i_b  (w_opb),
    .i_ci (r_carry),
    .o_s  (w_sum),
    .o_co (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) w_next = ST_RUN;
        else       w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= '0;
      r_a     <= a;
      // Subtract is a + ~b + 1; the +1 enters as the first carry.
      r_b     <= sub ? ~b : b;
      r_carry <= sub;
    end else if (r_state == ST_RUN) begin
      r_s[N*r_idx +: N] <= w_sum;
      r_carry           <= w_cout;
      if (w_last) begin
        r_co  <= w_cout;
        r_ovf <= w_cmsb ^ w_cout;
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  assign s   = r_s;
  assign co  = r_co;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed bench for mp_add_sequencer at N=8, K=4.
// Cycle 0 is the cycle start is driven; results expected in cycle 5.
module tb_mp_add_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] s;
  logic        co;
  logic        ovf;

  int checks = 0;
  int failures = 0;

  mp_add_sequencer #(.N(8), .K(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] va, input logic [31:0] vb,
                       input logic vs);
    start = 1'b1;
    a = va;
    b = vb;
    sub = vs;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    step();
    step();
    checks++;
    if ({busy, done, co, ovf, s} !== 36'h0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h",
               {busy, done, co, ovf, s}, 36'h0);
    end
    start = 1'b0;
    rst = 1'b0;
    step();
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_prio got=%b exp=00", {busy, done});
    end
  endtask

  // Issue one operation, check busy in cycles 1..4 and results in 5.
  task automatic test_vector(input string nm,
                             input logic [31:0] va,
                             input logic [31:0] vb,
                             input logic vs,
                             input logic [31:0] es,
                             input logic eco,
                             input logic eovf);
    drive(va, vb, vs);
    step();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if ({busy, done} !== 2'b10) begin
        failures++;
        $display("FAIL %s_busy c%0d got=%b exp=10", nm, c, {busy, done});
      end
      step();
    end
    checks++;
    if ({busy, done, co, ovf, s} !== {2'b01, eco, eovf, es}) begin
      failures++;
      $display("FAIL %s_done got=%h exp=%h", nm,
               {busy, done, co, ovf, s}, {2'b01, eco, eovf, es});
    end
    step();
    checks++;
    if ({busy, done, co, ovf, s} !== {2'b00, eco, eovf, es}) begin
      failures++;
      $display("FAIL %s_hold got=%h exp=%h", nm,
               {busy, done, co, ovf, s}, {2'b00, eco, eovf, es});
    end
  endtask

  task automatic test_arith();
    test_vector("ripple", 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0);
    test_vector("borrow", 32'h5, 32'h7, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    test_vector("ovf_add", 32'h7FFFFFFF, 32'h1, 1'b0,
                32'h80000000, 1'b0, 1'b1);
    test_vector("nobrw", 32'h7, 32'h5, 1'b1, 32'h2, 1'b1, 1'b0);
    test_vector("ovf_sub", 32'h80000000, 32'h1, 1'b1,
                32'h7FFFFFFF, 1'b1, 1'b1);
    test_vector("chunks", 32'h00FF00FF, 32'h00010001, 1'b0,
                32'h01000100, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    int ndone = 0;
    drive(32'h1, 32'h2, 1'b0);
    step();
    start = 1'b0;
    step();
    drive(32'h100, 32'h200, 1'b1);
    step();
    start = 1'b0;
    step();
    step();
    checks++;
    if ({done, co, ovf, s} !== {3'b100, 32'h3}) begin
      failures++;
      $display("FAIL ignore_done got=%h exp=%h",
               {done, co, ovf, s}, {3'b100, 32'h3});
    end
    for (int c = 6; c <= 10; c++) begin
      step();
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL ignore_extra got=%0d exp=0", ndone);
    end
  endtask

  task automatic test_back_to_back();
    drive(32'h1, 32'h1, 1'b0);
    step();
    start = 1'b0;
    repeat (4) step();
    drive(32'h12345678, 32'h11111111, 1'b0);
    checks++;
    if ({done, s} !== {1'b1, 32'h2}) begin
      failures++;
      $display("FAIL b2b_first got=%h exp=%h", {done, s}, {1'b1, 32'h2});
    end
    step();
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_rerun got=%b exp=10", {busy, done});
    end
    repeat (4) step();
    checks++;
    if ({done, co, ovf, s} !== {3'b100, 32'h23456789}) begin
      failures++;
      $display("FAIL b2b_second got=%h exp=%h",
               {done, co, ovf, s}, {3'b100, 32'h23456789});
    end
    step();
  endtask

  task automatic test_reset_midrun();
    int ndone = 0;
    drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({busy, done, co, ovf, s} !== 36'h0) begin
      failures++;
      $display("FAIL midrun_clear got=%h exp=%h",
               {busy, done, co, ovf, s}, 36'h0);
    end
    repeat (4) begin
      step();
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL midrun_nodone got=%0d exp=0", ndone);
    end
    test_vector("after_rst", 32'h10, 32'h20, 1'b0, 32'h30, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_start_ignored();
    test_back_to_back();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
